// File: rtl/reset_domain_sequencer_if.sv
// Request/ack/status bundle between a reset initiator and the sequencer.
// The sequencer sits on the slave side; whoever requests resets is master.
interface reset_domain_sequencer_if;
    logic io_req;
    logic io_ack_async;
    logic io_rst_out;
    logic io_busy;
    logic io_done;
    logic io_timeout;

    modport master (
        output io_req,
        output io_ack_async,
        input  io_rst_out,
        input  io_busy,
        input  io_done,
        input  io_timeout
    );

    modport slave (
        input  io_req,
        input  io_ack_async,
        output io_rst_out,
        output io_busy,
        output io_done,
        output io_timeout
    );
endinterface

// File: rtl/reset_domain_sequencer.sv
// Drives a reset into a target domain, holds it a minimum time, then
// waits for the target's synchronized reset to rise and fall again.
module reset_domain_sequencer #(
    parameter int HOLD_CYCLES    = 16,
    parameter int SYNC_STAGES    = 3,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                     clock,
    input  logic                     reset,
    reset_domain_sequencer_if.slave  bus
);

    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_CYCLES - 1);
    localparam logic [TW-1:0] TO_MAX   = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ASSERT  = 2'd1,
        RELEASE = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [HW-1:0]          hold_q, hold_d;
    logic [TW-1:0]          to_q, to_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   ack_sync;
    logic                   exit_ok;
    logic                   fin_ok;
    logic                   fin_to;
    logic                   rst_out_q, rst_out_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   tmo_q, tmo_d;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], bus.io_ack_async};
        end
    end

    assign ack_sync = sync_q[SYNC_STAGES-1];

    // Local reset parks the FSM in ASSERT so the target is sequenced at power-on.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= ASSERT;
            hold_q    <= '0;
            to_q      <= '0;
            rst_out_q <= 1'b1;
            busy_q    <= 1'b1;
            done_q    <= 1'b0;
            tmo_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            hold_q    <= hold_d;
            to_q      <= to_d;
            rst_out_q <= rst_out_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            tmo_q     <= tmo_d;
        end
    end

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        to_d    = to_q;
        exit_ok = 1'b0;
        fin_ok  = 1'b0;
        fin_to  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.io_req) state_d = ASSERT;
            end
            ASSERT: begin
                exit_ok = (hold_q == HOLD_MAX) && ack_sync;
                if (exit_ok) state_d = RELEASE;
            end
            RELEASE: begin
                exit_ok = !ack_sync;
                if (exit_ok) begin
                    state_d = IDLE;
                    fin_ok  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        // A same-cycle exit beats the timeout.
        if (state_q != IDLE && !exit_ok && to_q == TO_MAX) begin
            state_d = IDLE;
            fin_to  = 1'b1;
        end
        if (state_d != state_q) begin
            hold_d = '0;
            to_d   = '0;
        end else if (state_q != IDLE) begin
            if (to_q != TO_MAX) to_d = to_q + 1'b1;
            if (state_q == ASSERT && hold_q != HOLD_MAX) begin
                hold_d = hold_q + 1'b1;
            end
        end
    end

    always_comb begin
        rst_out_d = (state_d == ASSERT);
        busy_d    = (state_d != IDLE);
        done_d    = fin_ok;
        tmo_d     = fin_to;
    end

    assign bus.io_rst_out = rst_out_q;
    assign bus.io_busy    = busy_q;
    assign bus.io_done    = done_q;
    assign bus.io_timeout = tmo_q;

endmodule

// File: tb/tb_reset_domain_sequencer.sv
// Directed bench: expected completions are queued by the stimulus and
// checked by an independent monitor when done/timeout pulses.
module tb_reset_domain_sequencer;

    typedef struct {
        bit is_to;
        int run;
        int since;
    } exp_t;

    logic clk;
    logic rst_n;
    logic loop;
    logic force_val;
    exp_t q[$];
    int   checks;
    int   errs;
    int   run_len;
    int   last_run;
    int   since_fall;
    logic prev_rst;

    reset_domain_sequencer_if bus();

    reset_domain_sequencer dut (
        .clock (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    assign bus.io_ack_async = loop ? bus.io_rst_out : force_val;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic push(bit is_to, int run, int since);
        exp_t e;
        e.is_to = is_to;
        e.run   = run;
        e.since = since;
        q.push_back(e);
    endtask

    task automatic wait_empty(int maxc, string name);
        int n = 0;
        while (q.size() != 0 && n < maxc) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_drained"}, q.size(), 0);
        q.delete();
    endtask

    task automatic enter_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic leave_reset();
        @(negedge clk);
        #2 rst_n = 1'b1;
    endtask

    task automatic pulse_req();
        @(negedge clk);
        bus.io_req = 1'b1;
        @(negedge clk);
        bus.io_req = 1'b0;
    endtask

    // Late-ack stimulus: ack becomes visible to the synchronizer
    // 'dly' edges after the request edge.
    task automatic late_ack(int dly);
        loop      = 1'b0;
        force_val = 1'b0;
        @(negedge clk);
        bus.io_req = 1'b1;
        @(posedge clk);
        #1 bus.io_req = 1'b0;
        repeat (dly) @(posedge clk);
        @(negedge clk);
        loop = 1'b1;
    endtask

    // Monitor: track rst_out high-run length and cycles since its fall.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            run_len    = 1;
            since_fall = 0;
            prev_rst   = 1'b1;
        end else begin
            if (bus.io_rst_out) begin
                run_len = prev_rst ? run_len + 1 : 1;
            end else if (prev_rst) begin
                last_run   = run_len;
                since_fall = 0;
            end else begin
                since_fall++;
            end
            prev_rst = bus.io_rst_out;
            if (bus.io_done || bus.io_timeout) begin
                chk("done_and_timeout", int'(bus.io_done && bus.io_timeout), 0);
                if (q.size() == 0) begin
                    chk("unexpected_event", 1, 0);
                end else begin
                    e = q.pop_front();
                    chk("event_kind", int'(bus.io_timeout), int'(e.is_to));
                    chk("rst_len", last_run, e.run);
                    chk("since_fall", since_fall, e.since);
                    chk("busy_at_end", int'(bus.io_busy), 0);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, errs + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bit found;
        checks     = 0;
        errs       = 0;
        run_len    = 0;
        last_run   = 0;
        since_fall = 0;
        prev_rst   = 1'b0;
        loop       = 1'b1;
        force_val  = 1'b0;
        bus.io_req = 1'b0;
        rst_n      = 1'b1;
        #1 rst_n   = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_rst_out", int'(bus.io_rst_out), 1);
        chk("reset_busy", int'(bus.io_busy), 1);
        chk("reset_done", int'(bus.io_done), 0);
        chk("reset_timeout", int'(bus.io_timeout), 0);

        // power-on with loopback
        push(0, 16, 4);
        leave_reset();
        wait_empty(60, "poweron");

        // single request, second request while busy is dropped
        push(0, 16, 4);
        pulse_req();
        repeat (5) @(negedge clk);
        chk("req_busy", int'(bus.io_busy), 1);
        pulse_req();
        wait_empty(60, "req");
        repeat (10) @(negedge clk);
        chk("second_req_ignored", int'(bus.io_busy), 0);

        // request held across done restarts immediately
        push(0, 16, 4);
        push(0, 16, 4);
        @(negedge clk);
        bus.io_req = 1'b1;
        n = 0;
        while (q.size() > 1 && n < 60) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        chk("req_held_restart", int'(bus.io_busy), 1);
        bus.io_req = 1'b0;
        wait_empty(60, "held");

        // ack wiggles in IDLE do nothing
        loop      = 1'b0;
        force_val = 1'b1;
        repeat (10) @(negedge clk);
        chk("idle_ack_busy", int'(bus.io_busy), 0);
        chk("idle_ack_rst", int'(bus.io_rst_out), 0);
        force_val = 1'b0;
        repeat (5) @(negedge clk);

        // ack stuck low after power-on
        enter_reset();
        push(1, 1024, 0);
        leave_reset();
        wait_empty(1200, "ack_low");

        // ack stuck high: ASSERT exits, RELEASE times out
        force_val = 1'b1;
        enter_reset();
        push(1, 16, 1024);
        leave_reset();
        wait_empty(1200, "ack_high");
        loop = 1'b1;
        repeat (8) @(negedge clk);

        // ack_sync arrives exactly at to_cnt==1023
        push(0, 1024, 4);
        late_ack(1020);
        wait_empty(60, "late_exact");
        repeat (8) @(negedge clk);

        // one cycle later is a timeout
        push(1, 1024, 0);
        late_ack(1021);
        wait_empty(60, "late_over");
        repeat (8) @(negedge clk);

        // reset during RELEASE
        loop = 1'b1;
        pulse_req();
        found = 1'b0;
        n = 0;
        while (!found && n < 40) begin
            @(negedge clk);
            found = bus.io_busy && !bus.io_rst_out;
            n++;
        end
        chk("reached_release", int'(found), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_rst_out", int'(bus.io_rst_out), 1);
        chk("midrst_busy", int'(bus.io_busy), 1);
        chk("midrst_done", int'(bus.io_done), 0);
        chk("midrst_timeout", int'(bus.io_timeout), 0);
        push(0, 16, 4);
        repeat (3) @(negedge clk);
        leave_reset();
        wait_empty(60, "midrst");
        repeat (10) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, errs);
        $finish;
    end

endmodule

// File: doc/reset_domain_sequencer.md
# reset_domain_sequencer

Drives a reset into a target clock domain from the local domain and closes the loop on it. The local domain raises a request; the block asserts `io_rst_out` for a guaranteed minimum time. It then waits for the target domain's synchronized-reset acknowledge to rise and fall, and reports completion or timeout. It sits on the initiating side of each reset crossing: its `io_rst_out` feeds the target domain's reset synchronizer, and that synchronizer's output returns on `io_ack_async`.

## Interface
- `HOLD_CYCLES`, default 16: minimum cycles `io_rst_out` stays high; must be ≥1.
- `SYNC_STAGES`, default 3: flop depth of the internal `io_ack_async` synchronizer; must be ≥2.
- `TIMEOUT_CYCLES`, default 1024: per-phase limit for the ack to respond; must be > `HOLD_CYCLES`.
- `clock`  in  1  sole clock.
- `reset`  in  1  asynchronous, active-low reset of this block.
- `io_req`  in  1  reset request; level-sampled in IDLE only.
- `io_ack_async`  in  1  target domain's synchronized reset, asynchronous to `clock`; high means the target is in reset.
- `io_rst_out`  out  1  active-high reset to the target domain; registered and glitch-free.
- `io_busy`  out  1  high whenever the state is not IDLE.
- `io_done`  out  1  one-cycle pulse; sequence completed normally.
- `io_timeout`  out  1  one-cycle pulse; sequence aborted by the timeout.

## Operation
- The ack synchronizer is a `SYNC_STAGES`-flop chain reset to 0. Its last stage is `ack_sync`. The FSM uses only `ack_sync`.
- **States:**
  - **IDLE:** `rst_out`=0, `busy`=0. If `io_req`=1 → ASSERT.
  - **ASSERT:** `rst_out`=1.
    - `hold_cnt` counts from 0 on entry and saturates at `HOLD_CYCLES`-1.
    - When `hold_cnt`==`HOLD_CYCLES`-1 and `ack_sync`=1 → RELEASE.
  - **RELEASE:** `rst_out`=0. When `ack_sync`=0 → IDLE, with `io_done` pulsed.
- **Timeout:**
  - `to_cnt` clears on every state entry and increments each cycle in ASSERT or RELEASE.
  - If `to_cnt` reaches `TIMEOUT_CYCLES`-1 and the exit condition is false that cycle → IDLE, with `io_timeout` pulsed.
  - `rst_out` drops on entry to IDLE.
  - If the exit condition and the timeout occur in the same cycle, the exit condition wins and there is no timeout.
- **Reset state:** local `reset` low forces the FSM to ASSERT (power-on sequencing of the target).
  - Outputs during reset: `rst_out`=1, `busy`=1, `done`=0, `timeout`=0.
  - `hold_cnt`, `to_cnt` and the sync flops are 0.
  - After `reset` deasserts, the normal ASSERT sequence runs without any `io_req`.
- **Ignored inputs:**
  - `io_req` outside IDLE is ignored, not queued.
  - `io_req` still high in the cycle `io_done` or `io_timeout` pulses starts a new sequence on the next edge.
- `io_ack_async` changes in IDLE have no effect.
- Counters are sized to ceil(log2) of their limit. They never wrap.

## Timing
- All outputs are registered. There is no combinational path from an input to an output.
- **Request latency:** `io_req` sampled high in IDLE at edge k → `rst_out`=1 and `busy`=1 from edge k.
- **Assertion length:** `rst_out` stays high for max(`HOLD_CYCLES`, ack arrival + `SYNC_STAGES` + 1) cycles.
  - With loopback (`io_ack_async`=`io_rst_out`) and the default parameters, this is exactly 16 cycles.
- **Completion latency:** after `rst_out` falls in cycle c with loopback, `ack_sync` falls at c+`SYNC_STAGES`. `io_done`=1 and `busy`=0 in cycle c+`SYNC_STAGES`+1.
- `io_done` and `io_timeout` are never high together. Each is high for exactly one cycle.
- **Mid-sequence reset:** asserting `reset` at any time immediately drives the outputs to their reset values, asynchronously.

## Test plan
- **Power-on, loopback:** release `reset`, defaults → `rst_out` high for 16 cycles, then low. `io_done` pulses 4 cycles after the fall. `busy` falls with `done`.
- **Request in IDLE, loopback:** pulse `io_req` 1 cycle → `rst_out` high from the next cycle for 16 cycles. `done` pulses once. A second `io_req` during busy has no effect.
- **Ack stuck low:** `io_ack_async`=0 after power-on → `rst_out` high for 1024 cycles. Then `io_timeout` pulses, `rst_out`=0, `done` never asserts.
- **Ack stuck high:** force `io_ack_async`=1 → ASSERT exits after 16 cycles. RELEASE times out 1024 cycles later with a `io_timeout` pulse and `rst_out`=0.
- **Late ack, timeout boundary:** ack rises so that `ack_sync`=1 exactly at `to_cnt`=1023 → transition to RELEASE, no `io_timeout`.
- **Mid-sequence reset:** assert `reset` during RELEASE → `rst_out`=1, `busy`=1 asynchronously. After release, a full 16-cycle sequence runs and ends with `done`.
